// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the video PLL mode sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_RST   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STAB  = 3'd3,
    ST_IDLE  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_e;

  // Upper bounds for the generic table lookup; callers cast the result down.
  localparam int unsigned TBL_MAX_W  = 1024;
  localparam int unsigned DATA_MAX_W = 64;

  function automatic logic [DATA_MAX_W-1:0] mode_entry(
    input logic [TBL_MAX_W-1:0] tbl,
    input int unsigned          idx,
    input int unsigned          dw
  );
    logic [TBL_MAX_W-1:0]  shifted;
    logic [DATA_MAX_W-1:0] mask;
    shifted = tbl >> (idx * dw);
    mask    = (dw >= DATA_MAX_W) ? '1 : ((DATA_MAX_W'(1) << dw) - DATA_MAX_W'(1));
    return shifted[DATA_MAX_W-1:0] & mask;
  endfunction

  function automatic logic idx_is_bad(input int unsigned idx, input int unsigned num_modes);
    return idx >= num_modes;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameter-width two-flop synchroniser; stage1 is exposed so callers can
// register decisions that must line up with q one cycle later.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] stage1,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/pll_mode_sequencer.sv
// Video PLL mode sequencer: loads a mode word, pulses PLL reset, waits for a
// stable lock with timeout/retry. Optional relock_count under PLL_SEQ_STATS_EN.
//
// state | meaning
// LOAD  | latch table[target] onto pll_data, clear retries/error
// RST   | hold pll_reset for RESET_CYCLES
// WAIT  | wait for sync'd lock, timeout counter running
// STAB  | count consecutive locked cycles up to LOCK_STABLE
// IDLE  | locked and stable, accepting requests
// ERROR | retries exhausted, accepting requests
module pll_mode_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned                          NUM_MODES    = 4,
  parameter int unsigned                          DATA_WIDTH   = 8,
  parameter logic [NUM_MODES*DATA_WIDTH-1:0]      MODE_DATA    = 32'h03_02_01_00,
  parameter int unsigned                          INIT_MODE    = 0,
  parameter int unsigned                          RESET_CYCLES = 16,
  parameter int unsigned                          LOCK_TIMEOUT = 65535,
  parameter int unsigned                          LOCK_STABLE  = 256,
  parameter int unsigned                          MAX_RETRIES  = 3,
  localparam int unsigned                         MW           = $clog2(NUM_MODES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [MW-1:0]         mode_req,
  input  logic                  mode_req_valid,
  output logic                  mode_req_ready,
  input  logic                  pll_locked,
  output logic                  pll_reset,
  output logic [DATA_WIDTH-1:0] pll_data,
  output logic [MW-1:0]         mode_active,
  output logic                  mode_valid,
  output logic                  busy,
  output logic                  error,
  output logic                  bad_req,
  output logic                  lock_lost
`ifdef PLL_SEQ_STATS_EN
  ,
  output logic [15:0]           relock_count
`endif
);

  localparam int unsigned RCW = $clog2(RESET_CYCLES) + 1;
  localparam int unsigned TCW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned SCW = $clog2(LOCK_STABLE) + 1;
  localparam int unsigned RTW = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [TBL_MAX_W-1:0]  TBL_EXT   = TBL_MAX_W'(MODE_DATA);
  localparam logic [DATA_WIDTH-1:0] INIT_DATA =
    DATA_WIDTH'(mode_entry(TBL_EXT, INIT_MODE, DATA_WIDTH));

  seq_state_e            state_q, state_d;
  logic [MW-1:0]         target_q, target_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0]        to_cnt_q, to_cnt_d;
  logic [SCW-1:0]        stab_cnt_q, stab_cnt_d;
  logic [RTW-1:0]        retry_q, retry_d;

  logic                  pll_reset_d, mode_valid_d, busy_d, ready_d, error_d;
  logic                  bad_req_d, lock_lost_d;
  logic [DATA_WIDTH-1:0] pll_data_d;
  logic [MW-1:0]         mode_active_d;

  logic                  lock_s, lock_m;
  logic                  req_fire;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_locked),
    .stage1  (lock_m),
    .q       (lock_s)
  );

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    rst_cnt_d     = rst_cnt_q;
    to_cnt_d      = to_cnt_q;
    stab_cnt_d    = stab_cnt_q;
    retry_d       = retry_q;
    pll_reset_d   = pll_reset;
    pll_data_d    = pll_data;
    mode_active_d = mode_active;
    mode_valid_d  = mode_valid;
    busy_d        = busy;
    error_d       = error;
    bad_req_d     = 1'b0;
    lock_lost_d   = 1'b0;
    req_fire      = mode_req_valid && mode_req_ready;

    case (state_q)
      ST_LOAD: begin
        pll_data_d    = DATA_WIDTH'(mode_entry(TBL_EXT, 32'(target_q), DATA_WIDTH));
        mode_active_d = target_q;
        mode_valid_d  = 1'b0;
        busy_d        = 1'b1;
        retry_d       = '0;
        error_d       = 1'b0;
        pll_reset_d   = 1'b1;
        rst_cnt_d     = '0;
        state_d       = ST_RST;
      end
      ST_RST: begin
        if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
          pll_reset_d = 1'b0;
          to_cnt_d    = '0;
          state_d     = ST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          // the detecting cycle is the first of the LOCK_STABLE locked cycles
          stab_cnt_d = SCW'(1);
          state_d    = ST_STAB;
        end else if (to_cnt_q == TCW'(LOCK_TIMEOUT - 1)) begin
          if (retry_q < RTW'(MAX_RETRIES)) begin
            retry_d     = retry_q + 1'b1;
            pll_reset_d = 1'b1;
            rst_cnt_d   = '0;
            state_d     = ST_RST;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_ERROR;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_STAB: begin
        // timeout counter is frozen here and resumes if lock drops
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (stab_cnt_q >= SCW'(LOCK_STABLE - 1)) begin
          mode_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      ST_IDLE, ST_ERROR: begin
        if (state_q == ST_IDLE && !lock_s) begin
          lock_lost_d  = 1'b1;
          mode_valid_d = 1'b0;
          busy_d       = 1'b1;
          retry_d      = '0;
          pll_reset_d  = 1'b1;
          rst_cnt_d    = '0;
          state_d      = ST_RST;
        end else if (req_fire) begin
          if (idx_is_bad(32'(mode_req), NUM_MODES)) begin
            bad_req_d = 1'b1;
          end else begin
            target_d     = mode_req;
            mode_valid_d = 1'b0;
            busy_d       = 1'b1;
            error_d      = 1'b0;
            state_d      = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // lock_m is next cycle's lock_s, so ready drops together with the sync'd lock
    ready_d = (state_d == ST_ERROR) || (state_d == ST_IDLE && lock_m);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_LOAD;
      target_q       <= MW'(INIT_MODE);
      rst_cnt_q      <= '0;
      to_cnt_q       <= '0;
      stab_cnt_q     <= '0;
      retry_q        <= '0;
      pll_reset      <= 1'b1;
      pll_data       <= INIT_DATA;
      mode_active    <= MW'(INIT_MODE);
      mode_valid     <= 1'b0;
      busy           <= 1'b1;
      mode_req_ready <= 1'b0;
      error          <= 1'b0;
      bad_req        <= 1'b0;
      lock_lost      <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      rst_cnt_q      <= rst_cnt_d;
      to_cnt_q       <= to_cnt_d;
      stab_cnt_q     <= stab_cnt_d;
      retry_q        <= retry_d;
      pll_reset      <= pll_reset_d;
      pll_data       <= pll_data_d;
      mode_active    <= mode_active_d;
      mode_valid     <= mode_valid_d;
      busy           <= busy_d;
      mode_req_ready <= ready_d;
      error          <= error_d;
      bad_req        <= bad_req_d;
      lock_lost      <= lock_lost_d;
    end
  end

`ifdef PLL_SEQ_STATS_EN
  logic relock_evt;
  assign relock_evt = lock_lost_d || (state_q == ST_WAIT && state_d == ST_RST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      relock_count <= '0;
    end else if (relock_evt && relock_count != 16'hFFFF) begin
      relock_count <= relock_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed self-checking bench for pll_mode_sequencer (5-mode table, short timers).
module tb_pll_mode_sequencer;

  localparam int unsigned MW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [MW-1:0] mode_req = '0;
  logic          mode_req_valid = 1'b0;
  logic          mode_req_ready;
  logic          pll_locked = 1'b0;
  logic          pll_reset;
  logic [7:0]    pll_data;
  logic [MW-1:0] mode_active;
  logic          mode_valid, busy, error, bad_req, lock_lost;
`ifdef PLL_SEQ_STATS_EN
  logic [15:0]   relock_count;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  pll_mode_sequencer #(
    .NUM_MODES    (5),
    .DATA_WIDTH   (8),
    .MODE_DATA    (40'h04_03_02_01_00),
    .INIT_MODE    (0),
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .pll_locked     (pll_locked),
    .pll_reset      (pll_reset),
    .pll_data       (pll_data),
    .mode_active    (mode_active),
    .mode_valid     (mode_valid),
    .busy           (busy),
    .error          (error),
    .bad_req        (bad_req),
    .lock_lost      (lock_lost)
`ifdef PLL_SEQ_STATS_EN
    ,
    .relock_count   (relock_count)
`endif
  );

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Length in cycles of the next high pll_reset pulse, counting the current sample.
  task automatic measure_pulse(output int len);
    int guard;
    guard = 0;
    len   = 0;
    while (!pll_reset && guard < 50) begin
      step(1);
      guard++;
    end
    while (pll_reset && len < 50) begin
      len++;
      step(1);
    end
  endtask

  // Cycles spent with pll_reset low before the next pulse or the error flag.
  task automatic measure_wait(output int len);
    len = 0;
    while (!pll_reset && !error && len < 100) begin
      len++;
      step(1);
    end
  endtask

  // Raise lock while waiting; mode_valid must follow 2 sync + 8 stable cycles later.
  task automatic lock_and_check(input string tag);
    int cyc;
    pll_locked = 1'b1;
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!mode_valid && cyc < 40);
    chk(tag, cyc, 10);
  endtask

  initial begin
    step(2);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_pll_data", pll_data, 8'h00);
    chk("rst_mode_active", mode_active, 0);
    chk("rst_mode_valid", mode_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", mode_req_ready, 0);
    chk("rst_error", error, 0);
    chk("rst_bad_req", bad_req, 0);
    chk("rst_lock_lost", lock_lost, 0);
`ifdef PLL_SEQ_STATS_EN
    chk("rst_relock_count", relock_count, 0);
`endif

    // Power-up sequence on INIT_MODE; LOAD occupies the first edge after release.
    reset_n = 1'b1;
    step(1);
    measure_pulse(n);
    chk("init_pulse_len", n, 4);
    chk("init_pll_data", pll_data, 8'h00);
    step(10);
    lock_and_check("init_lock_latency");
    chk("init_busy", busy, 0);
    chk("init_ready", mode_req_ready, 1);
    chk("init_pll_reset", pll_reset, 0);

    // Mode change 0 -> 2.
    mode_req = 3'd2;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    pll_locked = 1'b0;
    chk("m2_accept_mode_valid", mode_valid, 0);
    chk("m2_accept_busy", busy, 1);
    chk("m2_accept_ready", mode_req_ready, 0);
    measure_pulse(n);
    chk("m2_pulse_len", n, 4);
    chk("m2_pll_data", pll_data, 8'h02);
    chk("m2_mode_active", mode_active, 2);
    chk("m2_mode_valid_low", mode_valid, 0);
    step(3);
    lock_and_check("m2_lock_latency");

    // Lock drop in IDLE while a request arrives in the same cycle.
    pll_locked = 1'b0;
    step(1);
    chk("ll_ready_before_sync", mode_req_ready, 1);
    step(1);
    chk("ll_ready_same_cycle", mode_req_ready, 0);
    chk("ll_mode_valid_before", mode_valid, 1);
    mode_req = 3'd3;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    chk("ll_lock_lost_pulse", lock_lost, 1);
    chk("ll_mode_valid", mode_valid, 0);
    chk("ll_pll_reset", pll_reset, 1);
    chk("ll_mode_active_same", mode_active, 2);
    chk("ll_pll_data_same", pll_data, 8'h02);
`ifdef PLL_SEQ_STATS_EN
    chk("ll_relock_count", relock_count, 1);
`endif
    step(1);
    chk("ll_lock_lost_one_cycle", lock_lost, 0);

    // Lock stays low: three attempts, then ERROR. First pulse already had one cycle sampled.
    measure_pulse(n);
    chk("try1_pulse_rest", n, 3);
    measure_wait(n);
    chk("try1_wait", n, 32);
    chk("try1_no_error", error, 0);
    measure_pulse(n);
    chk("try2_pulse", n, 4);
    measure_wait(n);
    chk("try2_wait", n, 32);
    chk("try2_no_error", error, 0);
    measure_pulse(n);
    chk("try3_pulse", n, 4);
    measure_wait(n);
    chk("try3_wait", n, 32);
    chk("err_error", error, 1);
    chk("err_busy", busy, 0);
    chk("err_ready", mode_req_ready, 1);
    chk("err_mode_valid", mode_valid, 0);
`ifdef PLL_SEQ_STATS_EN
    chk("err_relock_count", relock_count, 3);
`endif
    step(5);
    chk("err_no_fourth_pulse", pll_reset, 0);
    chk("err_sticky", error, 1);

    // Mode 1 request clears the error.
    mode_req = 3'd1;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    chk("m1_error_cleared", error, 0);
    chk("m1_busy", busy, 1);
    chk("m1_ready", mode_req_ready, 0);
    measure_pulse(n);
    chk("m1_pulse_len", n, 4);
    chk("m1_pll_data", pll_data, 8'h01);
    chk("m1_mode_active", mode_active, 1);

    // Sync'd lock low during the fifth STAB cycle, then locked for good.
    step(2);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(9);
    chk("stab_glitch_no_valid", mode_valid, 0);
    chk("stab_glitch_busy", busy, 1);
    step(1);
    chk("stab_relock_valid", mode_valid, 1);
    chk("stab_relock_busy", busy, 0);
    chk("stab_relock_ready", mode_req_ready, 1);

    // Out-of-range index 7 with five modes.
    mode_req = 3'd7;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    chk("bad_req_pulse", bad_req, 1);
    chk("bad_pll_data", pll_data, 8'h01);
    chk("bad_mode_active", mode_active, 1);
    chk("bad_mode_valid", mode_valid, 1);
    chk("bad_ready", mode_req_ready, 1);
    step(1);
    chk("bad_req_one_cycle", bad_req, 0);

    // Highest legal index, then a reset in the middle of the pulse.
    mode_req = 3'd4;
    mode_req_valid = 1'b1;
    step(1);
    mode_req_valid = 1'b0;
    chk("m4_no_bad_req", bad_req, 0);
    chk("m4_mode_valid", mode_valid, 0);
    step(2);
    chk("m4_pll_data", pll_data, 8'h04);
    chk("m4_pll_reset", pll_reset, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_pll_data", pll_data, 8'h00);
    chk("abort_mode_active", mode_active, 0);
    chk("abort_busy", busy, 1);
    chk("abort_ready", mode_req_ready, 0);
    chk("abort_pll_reset", pll_reset, 1);
`ifdef PLL_SEQ_STATS_EN
    chk("abort_relock_count", relock_count, 0);
`endif
    step(2);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_mode_sequencer.md
Name: pll_mode_sequencer

Overview:
- Parametrised controller that drives the video PLL's reconfiguration data and reset inputs, replacing the fixed data-tie-off / reset-tie-off wiring.
- Accepts a video-mode request, loads that mode's configuration word from a parameter table, pulses the PLL reset, waits for a stable lock with timeout and bounded retry, and reports status.
- Sits between top-level mode selection and pll_main; runs on the oscillator control clock.

Parameters:
- NUM_MODES, 4, number of selectable modes (>=2).
- DATA_WIDTH, 8, width of the PLL configuration word.
- MODE_DATA, {8'h03,8'h02,8'h01,8'h00}, packed NUM_MODES*DATA_WIDTH table; entry i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- INIT_MODE, 0, mode applied automatically after reset.
- RESET_CYCLES, 16, PLL reset pulse length in cycles.
- LOCK_TIMEOUT, 65535, maximum cycles to wait for lock per attempt.
- LOCK_STABLE, 256, consecutive locked cycles required before declaring lock.
- MAX_RETRIES, 3, re-attempts after the first timeout before error.

Ports:
- clock  in  1  control clock.
- reset_n  in  1  asynchronous active-low reset.
- mode_req  in  $clog2(NUM_MODES)  requested mode index.
- mode_req_valid  in  1  request strobe.
- mode_req_ready  out  1  high when a request can be accepted.
- pll_locked  in  1  PLL lock, asynchronous; 2-FF synchronised internally.
- pll_reset  out  1  active-high PLL reset.
- pll_data  out  DATA_WIDTH  PLL configuration word.
- mode_active  out  $clog2(NUM_MODES)  index of the mode last loaded.
- mode_valid  out  1  PLL locked and stable on mode_active.
- busy  out  1  sequence in progress.
- error  out  1  sticky; retries exhausted. Cleared on next accepted request.
- bad_req  out  1  one-cycle pulse: accepted request with index >= NUM_MODES.
- lock_lost  out  1  one-cycle pulse: sync'd lock dropped while mode_valid.

Behaviour:
- Reset values: pll_reset=1, pll_data=MODE_DATA[INIT_MODE], mode_active=INIT_MODE, mode_valid=0, busy=1, mode_req_ready=0, error=0, bad_req=0, lock_lost=0, retry count 0, FSM=LOAD with target INIT_MODE.
- All outputs registered.
- Handshake: the request is accepted on a cycle where mode_req_valid && mode_req_ready.
- mode_req_ready=1 only in IDLE and ERROR.
- Out-of-range index: accepted, bad_req pulses next cycle, state and outputs otherwise unchanged.
- FSM:
  - LOAD (1 cycle): pll_data<=table[target], mode_active<=target, mode_valid<=0, busy<=1, retries<=0, error<=0. Go to RST.
  - RST: pll_reset=1 for exactly RESET_CYCLES cycles, then deassert. Go to WAIT.
  - WAIT: timeout counter runs from 0. Sync'd lock high → STAB. Counter reaching LOCK_TIMEOUT-1 without lock → if retries<MAX_RETRIES, retries++ and go to RST; else go to ERROR.
  - STAB: counts consecutive locked cycles. Lock drop → back to WAIT, with the timeout counter continuing, not restarted. LOCK_STABLE cycles reached → IDLE with mode_valid=1, busy=0.
  - IDLE: a sync'd lock drop gives a lock_lost pulse, mode_valid=0, retries=0, then RST (auto-relock, same mode). A simultaneous valid request in that cycle is not accepted (ready deasserts the same cycle).
  - ERROR: error=1, busy=0, mode_valid=0, pll_reset=0. A valid in-range request goes to LOAD.
- Total attempts before error = MAX_RETRIES+1.
- pll_data only changes in LOAD, so it is stable across the entire reset pulse.
- Counters are sized $clog2 of their max value + 1 and never wrap.
- Reset mid-sequence aborts immediately to the reset values.

Optional Feature:
- Macro PLL_SEQ_STATS_EN.
- Defined: adds output relock_count [15:0], a saturating count (holds 16'hFFFF) of lock_lost events plus retry events. Cleared only by reset_n.
- Undefined: port absent, no counter logic.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum type (LOAD, RST, WAIT, STAB, IDLE, ERROR);
  - the function extracting table entry i from MODE_DATA;
  - the bad-index comparison helper.
- One sub-module, sync_2ff, a parameter-width two-flop synchroniser, used for pll_locked.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2):
- Reset release with pll_locked raised 10 cycles after pll_reset falls → pll_data=8'h00, pll_reset high exactly 4 cycles, mode_valid=1 after 2+8 further cycles, busy=0, ready=1.
- In IDLE, request mode 2 → pll_data=8'h02 next cycle, mode_active=2, mode_valid=0 until relock, new reset pulse of 4 cycles.
- pll_locked held low → exactly 3 reset pulses each followed by 32 wait cycles, then error=1, busy=0, ready=1. Subsequent mode 1 request clears error.
- Lock toggles low at STAB cycle 5 → returns to WAIT, no mode_valid; stays locked 8 cycles later → mode_valid=1.
- Request index 5 with NUM_MODES=4 (3-bit field via NUM_MODES=5 table check; use NUM_MODES=5, index 7) → bad_req one pulse, pll_data and mode_active unchanged.
- Drop lock in IDLE with a same-cycle request → lock_lost pulse, request not accepted, auto-relock on same mode. With PLL_SEQ_STATS_EN, relock_count increments by 1.
